// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: register addressing, scoreboard limits
// and the scoreboard drain FSM state type.
package riscv_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned LONG_OPS_MAX = 4;
  localparam int unsigned PEND_CNT_W   = 3;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_ACK   = 2'd2
  } sb_state_t;

  // One-hot decode of an architectural register index.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/scoreboard_unit.sv
// Register scoreboard for long-latency ops (loads, MUL/DIV): tracks pending
// writes, stalls hazardous issue from ID, and drains outstanding ops on request.
module scoreboard_unit
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  reg_write_id,
  input  logic                  long_lat_id,
  input  logic                  issue_valid_id,
  input  logic                  flush,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  drain_req,
  output logic                  stall_id,
  output logic                  issue_fire,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic [PEND_CNT_W-1:0] pending_cnt,
  output logic                  drain_ack,
  output logic                  sb_err
);

  sb_state_t             state_q;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [PEND_CNT_W-1:0] pending_q;
  logic [PEND_CNT_W-1:0] pending_d;

  logic raw1;
  logic raw2;
  logic waw;
  logic struct_haz;
  logic retire;
  logic set_busy;
  logic wb_err;

  // A retire only counts when it matches a genuinely outstanding op.
  assign retire = wb_valid & busy_q[rd_wb] & (pending_q != '0);
  assign wb_err = wb_valid & ~retire;

  // Hazards; a same-cycle writeback to the register hides it (write-first RF).
  assign raw1 = rs1_used_id & (rs1_id != REG_ZERO) & busy_q[rs1_id]
              & ~(wb_valid & (rd_wb == rs1_id));
  assign raw2 = rs2_used_id & (rs2_id != REG_ZERO) & busy_q[rs2_id]
              & ~(wb_valid & (rd_wb == rs2_id));
  assign waw  = reg_write_id & (rd_id != REG_ZERO) & busy_q[rd_id]
              & ~(wb_valid & (rd_wb == rd_id));

  // A full tracker frees a slot only through a real retire, so the count cannot overflow.
  assign struct_haz = long_lat_id & reg_write_id
                    & (pending_q == PEND_CNT_W'(LONG_OPS_MAX)) & ~retire;

  assign stall_id   = issue_valid_id
                    & (raw1 | raw2 | waw | struct_haz | (state_q != SB_IDLE));
  assign issue_fire = issue_valid_id & ~stall_id & ~flush;
  assign set_busy   = issue_fire & reg_write_id & long_lat_id & (rd_id != REG_ZERO);

  // Clear before set so a simultaneous retire and reissue of a register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (retire) begin
      busy_d = busy_d & ~reg_onehot(rd_wb);
    end
    if (set_busy) begin
      busy_d = busy_d | reg_onehot(rd_id);
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_d = pending_q;
    case ({set_busy, retire})
      2'b10:   pending_d = pending_q + PEND_CNT_W'(1);
      2'b01:   pending_d = pending_q - PEND_CNT_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      sb_err    <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      sb_err    <= sb_err | wb_err;
    end
  end

  // Drain FSM: even with nothing pending the request passes through SB_DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SB_IDLE;
      drain_ack <= 1'b0;
    end else begin
      drain_ack <= 1'b0;
      case (state_q)
        SB_IDLE: begin
          if (drain_req) begin
            state_q <= SB_DRAIN;
          end
        end
        SB_DRAIN: begin
          if ((pending_q == '0) && !set_busy) begin
            state_q   <= SB_ACK;
            drain_ack <= 1'b1;
          end
        end
        SB_ACK:  state_q <= SB_IDLE;
        default: state_q <= SB_IDLE;
      endcase
    end
  end

  assign busy_vec    = busy_q;
  assign pending_cnt = pending_q;

endmodule

// File: tb/tb_scoreboard_unit.sv
// Self-checking bench for scoreboard_unit: a behavioural model predicts each
// cycle's outputs, queued at drive time and compared after the clock edge.
module tb_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_id, rs2_id, rd_id, rd_wb;
  logic        rs1_used_id, rs2_used_id, reg_write_id, long_lat_id;
  logic        issue_valid_id, flush, wb_valid, drain_req;
  logic        stall_id, issue_fire, drain_ack, sb_err;
  logic [31:0] busy_vec;
  logic [2:0]  pending_cnt;

  scoreboard_unit dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .long_lat_id(long_lat_id),
    .issue_valid_id(issue_valid_id), .flush(flush),
    .wb_valid(wb_valid), .rd_wb(rd_wb), .drain_req(drain_req),
    .stall_id(stall_id), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .pending_cnt(pending_cnt), .drain_ack(drain_ack), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] busy;
    logic [2:0]  cnt;
    logic        err;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  bit m_busy[32];
  int m_cnt;
  bit m_err;
  int m_st;   // 0 idle, 1 drain, 2 ack
  int n_checks;
  int n_fail;
  int ack_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_retire();
    return wb_valid && m_busy[rd_wb] && (m_cnt > 0);
  endfunction

  function automatic bit model_stall();
    bit haz;
    haz = 1'b0;
    if (rs1_used_id && rs1_id != 0 && m_busy[rs1_id] && !(wb_valid && rd_wb == rs1_id)) haz = 1'b1;
    if (rs2_used_id && rs2_id != 0 && m_busy[rs2_id] && !(wb_valid && rd_wb == rs2_id)) haz = 1'b1;
    if (reg_write_id && rd_id != 0 && m_busy[rd_id] && !(wb_valid && rd_wb == rd_id)) haz = 1'b1;
    if (long_lat_id && reg_write_id && m_cnt == 4 && !model_retire()) haz = 1'b1;
    if (m_st != 0) haz = 1'b1;
    return issue_valid_id && haz;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    m_st  = 0;
  endfunction

  // Called at posedge+1 with inputs already applied; ends at the next posedge+1.
  task automatic tick(input string tag);
    bit   st, fire, ret, setb;
    int   cnt_old;
    exp_t e;
    #1;
    st   = model_stall();
    fire = issue_valid_id && !st && !flush;
    check({tag, "_stall"}, 32'(stall_id), 32'(st));
    check({tag, "_fire"}, 32'(issue_fire), 32'(fire));
    ret     = model_retire();
    setb    = fire && reg_write_id && long_lat_id && rd_id != 0;
    cnt_old = m_cnt;
    if (wb_valid && !ret) m_err = 1'b1;
    if (ret) begin
      m_busy[rd_wb] = 1'b0;
      m_cnt--;
    end
    if (setb) begin
      m_busy[rd_id] = 1'b1;
      m_cnt++;
    end
    e.ack = 1'b0;
    case (m_st)
      0: if (drain_req) m_st = 1;
      1: if (cnt_old == 0 && !setb) begin
           m_st  = 2;
           e.ack = 1'b1;
         end
      default: m_st = 0;
    endcase
    for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
    e.cnt = 3'(m_cnt);
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_busy"}, busy_vec, e.busy);
    check({tag, "_cnt"}, 32'(pending_cnt), 32'(e.cnt));
    check({tag, "_err"}, 32'(sb_err), 32'(e.err));
    check({tag, "_ack"}, 32'(drain_ack), 32'(e.ack));
    if (drain_ack) ack_seen++;
  endtask

  task automatic set_idle();
    rs1_id = '0; rs2_id = '0; rd_id = '0; rd_wb = '0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0; reg_write_id = 1'b0; long_lat_id = 1'b0;
    issue_valid_id = 1'b0; flush = 1'b0; wb_valid = 1'b0; drain_req = 1'b0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    set_idle();
    issue_valid_id = 1'b1;
    reg_write_id   = 1'b1;
    long_lat_id    = 1'b1;
    rd_id          = rd;
  endtask

  task automatic retire_only(input logic [4:0] rd);
    set_idle();
    wb_valid = 1'b1;
    rd_wb    = rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_vec, 32'h0);
    check({tag, "_cnt"}, 32'(pending_cnt), 32'h0);
    check({tag, "_err"}, 32'(sb_err), 32'h0);
    check({tag, "_ack"}, 32'(drain_ack), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ack_seen = 0;
    model_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Load to x5, dependent reader stalls until the writeback bypasses it.
    issue_long(5'd5);
    tick("ld_x5");
    set_idle();
    issue_valid_id = 1'b1; rs1_id = 5'd5; rs1_used_id = 1'b1; rd_id = 5'd7; reg_write_id = 1'b1;
    repeat (3) begin
      tick("raw_x5");
      check("raw_x5_hold", 32'(stall_id), 32'h1);
    end
    wb_valid = 1'b1; rd_wb = 5'd5;
    #1;
    check("bypass_stall", 32'(stall_id), 32'h0);
    check("bypass_fire", 32'(issue_fire), 32'h1);
    tick("bypass");
    set_idle();
    tick("idle0");

    // Fill the tracker, then a same-cycle retire lets the fifth op in.
    for (int i = 1; i <= 4; i++) begin
      issue_long(5'(i));
      tick("fill");
    end
    issue_long(5'd6);
    #1;
    check("full_stall", 32'(stall_id), 32'h1);
    check("full_cnt", 32'(pending_cnt), 32'h4);
    tick("full");
    wb_valid = 1'b1; rd_wb = 5'd1;
    #1;
    check("full_wb_fire", 32'(issue_fire), 32'h1);
    tick("full_wb");
    check("full_wb_cnt", 32'(pending_cnt), 32'h4);
    check("full_wb_busy", busy_vec, 32'h0000_005C);
    retire_only(5'd2); tick("ret2");
    retire_only(5'd3); tick("ret3");
    retire_only(5'd4); tick("ret4");
    retire_only(5'd6); tick("ret6");
    check("drained_cnt", 32'(pending_cnt), 32'h0);

    // Long op to x0 is ignored; x0 readers never stall.
    issue_long(5'd0);
    tick("x0_long");
    check("x0_busy", busy_vec, 32'h0);
    check("x0_cnt", 32'(pending_cnt), 32'h0);
    set_idle();
    issue_valid_id = 1'b1; rs1_id = 5'd0; rs1_used_id = 1'b1; rs2_id = 5'd0; rs2_used_id = 1'b1;
    #1;
    check("x0_read_stall", 32'(stall_id), 32'h0);
    tick("x0_read");

    // Writeback to an idle register is a sticky protocol error.
    retire_only(5'd9);
    tick("bad_wb");
    check("bad_wb_err", 32'(sb_err), 32'h1);
    check("bad_wb_cnt", 32'(pending_cnt), 32'h0);
    set_idle();
    tick("bad_wb_after");
    check("err_sticky", 32'(sb_err), 32'h1);

    // Drain with two outstanding ops.
    issue_long(5'd10); tick("dr_i10");
    issue_long(5'd11); tick("dr_i11");
    set_idle();
    drain_req = 1'b1;
    tick("dr_req");
    drain_req = 1'b0;
    issue_valid_id = 1'b1; rs1_id = 5'd20; rs1_used_id = 1'b1; rd_id = 5'd21; reg_write_id = 1'b1;
    #1;
    check("drain_stall", 32'(stall_id), 32'h1);
    tick("dr_hold");
    wb_valid = 1'b1; rd_wb = 5'd10; tick("dr_wb10");
    rd_wb = 5'd11; tick("dr_wb11");
    wb_valid = 1'b0;
    ack_seen = 0;
    repeat (4) tick("dr_tail");
    check("drain_ack_pulses", 32'(ack_seen), 32'h1);
    check("drain_done_stall", 32'(stall_id), 32'h0);

    // Drain with nothing pending acks exactly two cycles after the request.
    set_idle();
    drain_req = 1'b1;
    tick("dr0_req");
    drain_req = 1'b0;
    check("dr0_ack_c1", 32'(drain_ack), 32'h0);
    tick("dr0_c2");
    check("dr0_ack_c2", 32'(drain_ack), 32'h1);
    tick("dr0_c3");
    check("dr0_ack_c3", 32'(drain_ack), 32'h0);

    // Reset in the middle of a drain clears everything without an ack.
    issue_long(5'd12); tick("rs_i12");
    issue_long(5'd13); tick("rs_i13");
    issue_long(5'd14); tick("rs_i14");
    check("rs_cnt3", 32'(pending_cnt), 32'h3);
    set_idle();
    drain_req = 1'b1;
    tick("rs_req");
    drain_req = 1'b0;
    tick("rs_draining");
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_seen = 0;
    repeat (3) tick("post_rst");
    check("post_rst_no_ack", 32'(ack_seen), 32'h0);

    // Constrained random traffic against the model.
    repeat (300) begin
      set_idle();
      issue_valid_id = ($urandom_range(3, 0) != 0);
      rs1_id         = 5'($urandom_range(7, 0));
      rs2_id         = 5'($urandom_range(7, 0));
      rs1_used_id    = 1'($urandom_range(1, 0));
      rs2_used_id    = 1'($urandom_range(1, 0));
      rd_id          = 5'($urandom_range(7, 0));
      reg_write_id   = 1'($urandom_range(1, 0));
      long_lat_id    = 1'($urandom_range(1, 0));
      flush          = ($urandom_range(7, 0) == 0);
      wb_valid       = ($urandom_range(2, 0) == 0);
      rd_wb          = 5'($urandom_range(7, 0));
      drain_req      = ($urandom_range(19, 0) == 0);
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_unit.md
SCOREBOARD_UNIT -- requirements
Module: scoreboard_unit

Interface
REQ-001 SHALL expose clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL expose rs1_id, rs2_id  input  5 each  source registers of the instruction in ID.
REQ-004 SHALL expose rs1_used_id, rs2_used_id  input  1 each  source operand is actually read.
REQ-005 SHALL expose rd_id  input  5, reg_write_id  input  1  destination and write-enable of the ID instruction.
REQ-006 SHALL expose long_lat_id  input  1  ID instruction is a load or MUL/DIV; its result is not forwardable from EX/MEM.
REQ-007 SHALL expose issue_valid_id  input  1  ID holds a valid instruction requesting issue to EX.
REQ-008 SHALL expose flush  input  1  squash the ID instruction this cycle.
REQ-009 SHALL expose wb_valid  input  1, rd_wb  input  5  long-latency result retires to rd_wb this cycle.
REQ-010 SHALL expose drain_req  input  1  level request to drain all outstanding long-latency ops (fence/CSR).
REQ-011 SHALL expose stall_id  output  1  hold ID/IF; do not issue.
REQ-012 SHALL expose issue_fire  output  1  ID instruction issues this cycle.
REQ-013 SHALL expose busy_vec  output  32  per-register pending-write bits.
REQ-014 SHALL expose pending_cnt  output  3  outstanding long-latency ops, 0..LONG_OPS_MAX.
REQ-015 SHALL expose drain_ack  output  1  one-cycle pulse: drain complete.
REQ-016 SHALL expose sb_err  output  1  sticky protocol error.

Function
REQ-017 issue_fire SHALL equal issue_valid_id & !stall_id & !flush.
REQ-018 stall_id SHALL assert (combinationally) on: RAW (rsN_used_id & busy_vec[rsN_id] & rsN_id!=REG_ZERO, not cleared by same-cycle wb); WAW (reg_write_id & rd_id!=REG_ZERO & busy_vec[rd_id], same bypass); structural (long_lat_id & reg_write_id & pending_cnt==LONG_OPS_MAX & !wb_valid); FSM state != SB_IDLE; only when issue_valid_id=1.
REQ-019 Same-cycle bypass: wb_valid & rd_wb==rsN_id SHALL remove that register's RAW/WAW stall contribution (register file is write-first).
REQ-020 On issue_fire & reg_write_id & long_lat_id & rd_id!=REG_ZERO, busy_vec[rd_id] SHALL set next cycle and pending_cnt SHALL increment.
REQ-021 On wb_valid with busy_vec[rd_wb]=1, that bit SHALL clear next cycle and pending_cnt SHALL decrement.
REQ-022 Simultaneous set and clear of the same register SHALL leave the bit set; pending_cnt unchanged.
REQ-023 busy_vec[0] SHALL always read 0.
REQ-024 wb_valid with busy_vec[rd_wb]=0 or pending_cnt==0 SHALL set sb_err; busy_vec and pending_cnt unchanged (no underflow).
REQ-025 pending_cnt SHALL never exceed LONG_OPS_MAX (guaranteed by REQ-018 structural stall).
REQ-026 flush SHALL not alter busy_vec or pending_cnt (already-issued ops still retire).
REQ-027 FSM states SB_IDLE, SB_DRAIN, SB_ACK: IDLE->DRAIN on drain_req; DRAIN->ACK when pending_cnt==0 and no set that cycle; ACK->IDLE unconditionally; drain_ack=1 only in SB_ACK.
REQ-028 drain_req with pending_cnt==0 SHALL still pass through SB_DRAIN (ack latency exactly 2 cycles after request).

Reset
REQ-029 On rst: busy_vec=0, pending_cnt=0, sb_err=0, state=SB_IDLE, drain_ack=0, immediately and asynchronously.
REQ-030 rst mid-drain SHALL abort the drain without drain_ack.

Structure
REQ-031 LONG_OPS_MAX (=4) and typedef sb_state_t SHALL live in riscv_pkg; REG_ZERO reused from it.
REQ-032 Single flat module; no sub-module.

Verification
REQ-033 Issue load x5, next cycle instr reads x5 -> stall_id=1 until wb_valid rd_wb=5; in that wb cycle stall_id=0, issue_fire=1.
REQ-034 Issue 4 long ops x1..x4, 5th long op x6 -> stall_id=1, pending_cnt=4; same cycle wb x1 -> 5th issues, pending_cnt stays 4.
REQ-035 Long op to x0 -> busy_vec=0, pending_cnt=0; reading x0 never stalls.
REQ-036 wb_valid rd_wb=9 with x9 not busy -> sb_err=1 sticky, pending_cnt unchanged.
REQ-037 drain_req with 2 pending -> stall_id=1 for all issue; after last wb, drain_ack pulses 1 cycle, state returns SB_IDLE.
REQ-038 rst asserted during SB_DRAIN with 3 pending -> all outputs zero asynchronously, no drain_ack.
